// File: rtl/audio_pkg.sv
// Shared audio types: sample width, stereo pair payload and underrun counter width.
package audio_pkg;

  localparam int unsigned SAMPLE_W       = 16;
  localparam int unsigned UNDERRUN_CNT_W = 16;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/sample_feeder_if.sv
// Producer-side handshake and codec-side data/status bundle of the sample feeder.
import audio_pkg::*;

interface sample_feeder_if #(
  parameter int unsigned ADDR_W = 4
);
  logic [SAMPLE_W-1:0]       in_left;
  logic [SAMPLE_W-1:0]       in_right;
  logic                      in_valid;
  logic                      in_ready;
  logic [SAMPLE_W-1:0]       data_left;
  logic [SAMPLE_W-1:0]       data_right;
  logic [ADDR_W:0]           fill_level;
  logic                      underrun;
  logic [UNDERRUN_CNT_W-1:0] underrun_count;

  modport master (
    output in_left, in_right, in_valid,
    input  in_ready, data_left, data_right, fill_level, underrun, underrun_count
  );

  modport slave (
    input  in_left, in_right, in_valid,
    output in_ready, data_left, data_right, fill_level, underrun, underrun_count
  );
endinterface

// File: rtl/lrclk_sync.sv
// Brings an asynchronous codec LR clock into the clk domain and emits a one-cycle
// registered strobe on each rising edge (asserts on the 3rd clk edge after the rise).
module lrclk_sync (
  input  logic clk,
  input  logic rst,
  input  logic daclrc,
  output logic frame_stb
);

  logic sync_1;
  logic sync_2;
  logic sync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_d    <= 1'b0;
      frame_stb <= 1'b0;
    end else begin
      sync_1    <= daclrc;
      sync_2    <= sync_1;
      sync_d    <= sync_2;
      frame_stb <= sync_2 & ~sync_d;
    end
  end

endmodule

// File: rtl/sample_feeder.sv
// Stereo FIFO feeding the codec serializer one pair per daclrc frame.
// Build option SAMPLE_FEEDER_ZERO_ON_UNDERRUN_EN: output silence on underrun instead of repeating.
import audio_pkg::*;

module sample_feeder #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   daclrc,
  sample_feeder_if.slave         bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  stereo_sample_t              mem [DEPTH];
  stereo_sample_t              data_q;
  logic [ADDR_W-1:0]           wr_ptr;
  logic [ADDR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]            count;
  logic                        underrun_q;
  logic [UNDERRUN_CNT_W-1:0]   underrun_cnt_q;
  logic                        frame_stb;
  logic                        in_ready_c;
  logic                        fifo_empty_c;
  logic                        push_c;
  logic                        pop_c;
  logic                        und_c;

  lrclk_sync u_lrclk_sync (
    .clk       (clk),
    .rst       (rst),
    .daclrc    (daclrc),
    .frame_stb (frame_stb)
  );

  // A full FIFO refuses the push even when a pop frees a slot in the same cycle.
  assign in_ready_c   = !rst && (count != CNT_W'(DEPTH));
  assign fifo_empty_c = (count == '0);
  assign push_c       = bus.in_valid && in_ready_c;
  assign pop_c        = frame_stb && !fifo_empty_c;
  assign und_c        = frame_stb && fifo_empty_c;

  // Sample storage, no reset needed.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= stereo_sample_t'{left: bus.in_left, right: bus.in_right};
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Codec-facing pair, underrun pulse and saturating underrun counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q         <= '0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      underrun_q <= und_c;
      if (pop_c) begin
        data_q <= mem[rd_ptr];
      end
`ifdef SAMPLE_FEEDER_ZERO_ON_UNDERRUN_EN
      else if (und_c) begin
        data_q <= '0;
      end
`endif
      if (und_c && (underrun_cnt_q != '1)) begin
        underrun_cnt_q <= underrun_cnt_q + UNDERRUN_CNT_W'(1);
      end
    end
  end

  assign bus.in_ready       = in_ready_c;
  assign bus.data_left      = data_q.left;
  assign bus.data_right     = data_q.right;
  assign bus.fill_level     = count;
  assign bus.underrun       = underrun_q;
  assign bus.underrun_count = underrun_cnt_q;

endmodule

// File: tb/tb_sample_feeder.sv
// Directed self-checking bench for sample_feeder (honours SAMPLE_FEEDER_ZERO_ON_UNDERRUN_EN).
module tb_sample_feeder;

  logic clk = 1'b0;
  logic rst;
  logic daclrc;
  int   checks   = 0;
  int   failures = 0;

  sample_feeder_if #(.ADDR_W(4)) sf ();

  sample_feeder #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .daclrc (daclrc),
    .bus    (sf.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    @(negedge clk);
    sf.in_left  = l;
    sf.in_right = r;
    sf.in_valid = 1'b1;
    @(negedge clk);
    sf.in_valid = 1'b0;
  endtask

  // Leaves the bench just after the 3rd clk edge following the daclrc rise.
  task automatic frame_rise();
    @(negedge clk);
    daclrc = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic frame_done();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_fall();
    @(negedge clk);
    daclrc = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame();
    frame_rise();
    frame_done();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp_l [3];
    logic [15:0] exp_r [3];
    logic [15:0] prev_l;
    logic [15:0] rpt_l;
    logic [15:0] rpt_r;
    exp_l = '{16'h1111, 16'h3333, 16'h5555};
    exp_r = '{16'h2222, 16'h4444, 16'h6666};

    rst         = 1'b1;
    daclrc      = 1'b0;
    sf.in_valid = 1'b0;
    sf.in_left  = '0;
    sf.in_right = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_fill",     32'(sf.fill_level), 32'd0);
    check_eq("rst_ready",    32'(sf.in_ready), 32'd0);
    check_eq("rst_left",     32'(sf.data_left), 32'd0);
    check_eq("rst_right",    32'(sf.data_right), 32'd0);
    check_eq("rst_underrun", 32'(sf.underrun), 32'd0);
    check_eq("rst_ucount",   32'(sf.underrun_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("ready_after_rst", 32'(sf.in_ready), 32'd1);

    // Three pairs served in order, each 4 clk after its daclrc rise.
    for (int i = 0; i < 3; i++) push(exp_l[i], exp_r[i]);
    check_eq("t1_fill", 32'(sf.fill_level), 32'd3);
    prev_l = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      frame_rise();
      check_eq("t1_hold_3clk", 32'(sf.data_left), 32'(prev_l));
      frame_done();
      check_eq("t1_left",  32'(sf.data_left), 32'(exp_l[i]));
      check_eq("t1_right", 32'(sf.data_right), 32'(exp_r[i]));
      prev_l = exp_l[i];
      frame_fall();
    end
    check_eq("t1_ucount", 32'(sf.underrun_count), 32'd0);
    check_eq("t1_fill_empty", 32'(sf.fill_level), 32'd0);

    // Three underruns on an empty FIFO.
`ifdef SAMPLE_FEEDER_ZERO_ON_UNDERRUN_EN
    rpt_l = 16'h0000;
    rpt_r = 16'h0000;
`else
    rpt_l = 16'h5555;
    rpt_r = 16'h6666;
`endif
    for (int i = 0; i < 3; i++) begin
      frame();
      check_eq("ur_pulse", 32'(sf.underrun), 32'd1);
      check_eq("ur_left",  32'(sf.data_left), 32'(rpt_l));
      check_eq("ur_right", 32'(sf.data_right), 32'(rpt_r));
      @(posedge clk);
      #1;
      check_eq("ur_pulse_end", 32'(sf.underrun), 32'd0);
      frame_fall();
    end
    check_eq("ur_count3", 32'(sf.underrun_count), 32'd3);

    // Fill to DEPTH with in_valid held for 17 cycles; the 17th must be refused.
    @(negedge clk);
    sf.in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      sf.in_left  = 16'h0100 + 16'(i);
      sf.in_right = 16'h0200 + 16'(i);
      @(negedge clk);
    end
    sf.in_valid = 1'b0;
    check_eq("full_fill",  32'(sf.fill_level), 32'd16);
    check_eq("full_ready", 32'(sf.in_ready), 32'd0);
    frame();
    check_eq("full_pop_left", 32'(sf.data_left), 32'h0100);
    check_eq("full_pop_fill", 32'(sf.fill_level), 32'd15);
    check_eq("full_ready_back", 32'(sf.in_ready), 32'd1);
    frame_fall();
    for (int i = 1; i < 12; i++) begin
      frame();
      check_eq("drain_left",  32'(sf.data_left), 32'h0100 + 32'(i));
      check_eq("drain_right", 32'(sf.data_right), 32'h0200 + 32'(i));
      frame_fall();
    end
    check_eq("fill_four", 32'(sf.fill_level), 32'd4);

    // Push lands on the same edge as the pop.
    frame_rise();
    sf.in_left  = 16'hBEEF;
    sf.in_right = 16'hCAFE;
    sf.in_valid = 1'b1;
    frame_done();
    sf.in_valid = 1'b0;
    check_eq("sim_left",  32'(sf.data_left), 32'h010C);
    check_eq("sim_right", 32'(sf.data_right), 32'h020C);
    check_eq("sim_fill",  32'(sf.fill_level), 32'd4);
    frame_fall();
    for (int i = 13; i < 16; i++) begin
      frame();
      check_eq("sim_drain_left", 32'(sf.data_left), 32'h0100 + 32'(i));
      frame_fall();
    end
    frame();
    check_eq("sim_pushed_left",  32'(sf.data_left), 32'hBEEF);
    check_eq("sim_pushed_right", 32'(sf.data_right), 32'hCAFE);
    check_eq("sim_no_underrun",  32'(sf.underrun), 32'd0);
    check_eq("sim_fill_zero",    32'(sf.fill_level), 32'd0);
    frame_fall();

    // Asynchronous reset mid-stream.
    push(16'hABCD, 16'h1234);
    for (int i = 0; i < 5; i++) push(16'h0A00 + 16'(i), 16'h0B00 + 16'(i));
    frame();
    check_eq("mid_left", 32'(sf.data_left), 32'hABCD);
    check_eq("mid_fill", 32'(sf.fill_level), 32'd5);
    frame_fall();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_left",  32'(sf.data_left), 32'd0);
    check_eq("async_right", 32'(sf.data_right), 32'd0);
    check_eq("async_fill",  32'(sf.fill_level), 32'd0);
    check_eq("async_ready", 32'(sf.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    frame();
    check_eq("post_rst_underrun", 32'(sf.underrun), 32'd1);
    check_eq("post_rst_ucount",   32'(sf.underrun_count), 32'd1);
    frame_fall();

    // Counter saturation from 16'hFFFE.
    @(negedge clk);
    force dut.underrun_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.underrun_cnt_q;
    #1;
    check_eq("sat_preset", 32'(sf.underrun_count), 32'h0000FFFE);
    for (int i = 0; i < 3; i++) begin
      frame();
      check_eq("sat_pulse", 32'(sf.underrun), 32'd1);
      check_eq("sat_count", 32'(sf.underrun_count), 32'h0000FFFF);
      frame_fall();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
